dff_bist: RTL

//  Synthesizable stimulus/response engine for a registered data path: it drives d and checks q.

---
 rtl/dff_bist.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dff_bist.sv
// Self-test engine for a registered datapath: resets the DUT, checks q clears,
// streams fixed and LFSR patterns into d and compares q after DEPTH cycles.
module dff_bist #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEPTH       = 1,
   parameter int unsigned NUM_VECTORS = 256,
   parameter logic [15:0] SEED        = 16'hACE1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             dut_rst_n,
   output logic [WIDTH-1:0] dut_d,
   input  logic [WIDTH-1:0] dut_q,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             rst_err,
   output logic [CNT_W-1:0] err_count,
   output logic [15:0]      first_err_idx
);

   localparam int unsigned IDX_W = 16;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RST   = 3'd1;
   localparam logic [2:0] S_RCHK  = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};
   localparam logic [IDX_W-1:0] NO_ERR   = 16'hFFFF;
   localparam logic [IDX_W-1:0] RUN_LAST = IDX_W'(NUM_VECTORS - 1);
   localparam logic [IDX_W-1:0] DRN_LAST = IDX_W'(DEPTH - 1);

   logic [2:0]       state, state_nxt;
   logic [IDX_W-1:0] cnt, cnt_nxt;
   logic [IDX_W-1:0] cmp_idx, cmp_idx_nxt;
   logic [15:0]      lfsr, lfsr_nxt;
   logic             d_vld, d_vld_nxt;
   logic             dut_rst_n_nxt;
   logic [WIDTH-1:0] dut_d_nxt;
   logic             busy_nxt, done_nxt, pass_nxt, rst_err_nxt;
   logic [CNT_W-1:0] err_nxt;
   logic [IDX_W-1:0] fei_nxt;

   // expected-value pipe; entry 0 follows dut_d, the last entry lines up with dut_q
   logic [WIDTH-1:0] exp_data [DEPTH];
   logic             exp_vld  [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         cmp_idx       <= '0;
         lfsr          <= SEED;
         d_vld         <= 1'b0;
         dut_rst_n     <= 1'b0;
         dut_d         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         rst_err       <= 1'b0;
         err_count     <= '0;
         first_err_idx <= NO_ERR;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         cmp_idx       <= cmp_idx_nxt;
         lfsr          <= lfsr_nxt;
         d_vld         <= d_vld_nxt;
         dut_rst_n     <= dut_rst_n_nxt;
         dut_d         <= dut_d_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         pass          <= pass_nxt;
         rst_err       <= rst_err_nxt;
         err_count     <= err_nxt;
         first_err_idx <= fei_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            exp_data[i] <= '0;
            exp_vld[i]  <= 1'b0;
         end
      end else begin
         exp_data[0] <= dut_d;
         exp_vld[0]  <= d_vld;
         for (int i = 1; i < DEPTH; i++) begin
            exp_data[i] <= exp_data[i-1];
            exp_vld[i]  <= exp_vld[i-1];
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      cmp_idx_nxt   = cmp_idx;
      lfsr_nxt      = lfsr;
      d_vld_nxt     = 1'b0;
      dut_rst_n_nxt = 1'b1;
      dut_d_nxt     = '0;
      done_nxt      = 1'b0;
      pass_nxt      = pass;
      rst_err_nxt   = rst_err;
      err_nxt       = err_count;
      fei_nxt       = first_err_idx;

      // response check; compares arrive in vector order so cmp_idx equals k
      if (exp_vld[DEPTH-1]) begin
         cmp_idx_nxt = cmp_idx + 1'b1;
         if (dut_q != exp_data[DEPTH-1]) begin
            if (err_count != ERR_MAX) err_nxt = err_count + 1'b1;
            if (first_err_idx == NO_ERR) fei_nxt = cmp_idx;
         end
      end

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt   = S_RST;
               cnt_nxt     = '0;
               cmp_idx_nxt = '0;
               lfsr_nxt    = SEED;
               rst_err_nxt = 1'b0;
               err_nxt     = '0;
               fei_nxt     = NO_ERR;
            end
         end
         S_RST: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == IDX_W'(1)) begin
               state_nxt = S_RCHK;
               cnt_nxt   = '0;
            end
         end
         S_RCHK: begin
            if (dut_q != '0) rst_err_nxt = 1'b1;
            state_nxt = S_RUN;
            cnt_nxt   = '0;
         end
         S_RUN: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == RUN_LAST) begin
               state_nxt = S_DRAIN;
               cnt_nxt   = '0;
            end
         end
         S_DRAIN: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == DRN_LAST) begin
               state_nxt = S_DONE;
               cnt_nxt   = '0;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      // outputs are registered against the state being entered
      if (state_nxt == S_RST) dut_rst_n_nxt = 1'b0;
      if (state_nxt == S_RUN) begin
         d_vld_nxt = 1'b1;
         if (cnt_nxt == '0) begin
            dut_d_nxt = '0;
         end else if (cnt_nxt == IDX_W'(1)) begin
            dut_d_nxt = '1;
         end else begin
            dut_d_nxt = lfsr[WIDTH-1:0];
            lfsr_nxt  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
         end
      end
      if (state_nxt == S_DONE) begin
         done_nxt = 1'b1;
         pass_nxt = (err_nxt == '0) && !rst_err_nxt;
      end
      busy_nxt = (state_nxt != S_IDLE);
   end

endmodule
